gpio_port: RTL

- CPU-facing I/O port for the 282CPU system. It sits on the device side of the same pins the system exposes: it drives the `led` outputs from a CPU-written register and presents the `switch` inputs to the CPU.
- Switch inputs are synchronized, debounced and edge-flagged, and can raise a maskable interrupt.
- The CPU accesses four word registers over a simple single-cycle read/write strobe bus.

---
 rtl/gpio_pkg.sv | 13 +
 rtl/switch_debounce.sv | 47 ++++
 rtl/gpio_port.sv | 110 +++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the CPU-facing GPIO port: register addresses and bus width.
// No logic; pure declarations.
// Imported by gpio_port and its bench.
package gpio_pkg;

  localparam int GPIO_BUS_W = 8;

  localparam logic [1:0] GPIO_ADDR_LED  = 2'd0;
  localparam logic [1:0] GPIO_ADDR_SW   = 2'd1;
  localparam logic [1:0] GPIO_ADDR_CHG  = 2'd2;
  localparam logic [1:0] GPIO_ADDR_MASK = 2'd3;

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: two-flop synchronizer, consecutive-difference counter, stable flop.
// Latency: a clean edge on raw reaches stable after 2 + DEBOUNCE_CYCLES rising edges.
// No backpressure; toggle is a single-cycle pulse coincident with the edge stable flips on.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic stable,
  output logic toggle
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          stable_q;

  // The flop flips on this edge when the last allowed differing cycle is reached.
  assign toggle = (sync2 != stable_q) && (cnt == CNT_MAX);
  assign stable = stable_q;

  // Synchronize the raw input, then accept it only after an unbroken run of differing samples.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      cnt      <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable_q) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable_q <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_port.sv
// CPU GPIO port: LED register, debounced switch inputs, sticky change flags, maskable irq.
// Latency: writes land on the strobe edge; reads return one cycle after rd_en; irq one cycle after its condition.
// No backpressure: every strobe is accepted in its cycle; read data holds until the next read.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [GPIO_BUS_W-1:0] wdata,
  output logic [GPIO_BUS_W-1:0] rdata,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      led,
  input  logic [WIDTH-1:0]      switch,
  output logic                  irq
);

  logic [WIDTH-1:0]      led_q;
  logic [WIDTH-1:0]      mask_q;
  logic [WIDTH-1:0]      chg_q;
  logic [WIDTH-1:0]      sw_stable;
  logic [WIDTH-1:0]      sw_toggle;
  logic [WIDTH-1:0]      chg_clr;
  logic [GPIO_BUS_W-1:0] rd_mux;

  // Bus bits above WIDTH carry nothing.
  if (WIDTH < GPIO_BUS_W) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[GPIO_BUS_W-1:WIDTH];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .CLK   (CLK),
      .RST   (RST),
      .raw   (switch[i]),
      .stable(sw_stable[i]),
      .toggle(sw_toggle[i])
    );
  end

  assign led = led_q;

  // Write-1-to-clear mask for the change flags, active only on a CHANGE write.
  always_comb begin
    chg_clr = '0;
    if (wr_en && addr == GPIO_ADDR_CHG) begin
      chg_clr = wdata[WIDTH-1:0];
    end
  end

  // Read mux over current register contents, zero-extended to the bus.
  always_comb begin
    rd_mux = '0;
    case (addr)
      GPIO_ADDR_LED:  rd_mux = GPIO_BUS_W'(led_q);
      GPIO_ADDR_SW:   rd_mux = GPIO_BUS_W'(sw_stable);
      GPIO_ADDR_CHG:  rd_mux = GPIO_BUS_W'(chg_q);
      GPIO_ADDR_MASK: rd_mux = GPIO_BUS_W'(mask_q);
      default:        rd_mux = '0;
    endcase
  end

  // Writable registers; a toggle on the same edge as a clear keeps the flag set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      led_q  <= '0;
      mask_q <= '0;
      chg_q  <= '0;
    end else begin
      if (wr_en && addr == GPIO_ADDR_LED) begin
        led_q <= wdata[WIDTH-1:0];
      end
      if (wr_en && addr == GPIO_ADDR_MASK) begin
        mask_q <= wdata[WIDTH-1:0];
      end
      chg_q <= (chg_q & ~chg_clr) | sw_toggle;
    end
  end

  // Registered read response; data sampled before any same-cycle write lands.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

  // Level interrupt from enabled change flags, one cycle behind the flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      irq <= 1'b0;
    end else begin
      irq <= |(chg_q & mask_q);
    end
  end

endmodule
